dft_frame_sequencer: RTL and testbench

//  Streaming controller that sequences the 32-point dft_top core without software word-by-word access.

---
 rtl/dft_pkg.sv | 17 +
 rtl/dft_seq_buf.sv | 25 ++
 rtl/dft_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_dft_frame_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared definitions for the DFT frame sequencer: default geometry and FSM state encoding.
package dft_pkg;

  localparam int unsigned DFT_FRAME_WORDS = 32;
  localparam int unsigned DFT_DW          = 64;
  localparam int unsigned DFT_TIMEOUT     = 1024;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_FEED,
    ST_WAIT,
    ST_CAPTURE,
    ST_DRAIN
  } seq_state_e;

endpackage

// File: rtl/dft_seq_buf.sv
// Single-frame word buffer: one synchronous write port, one asynchronous read port.
module dft_seq_buf
  import dft_pkg::*;
#(
  parameter  int unsigned DEPTH = DFT_FRAME_WORDS,
  parameter  int unsigned DW    = DFT_DW,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dft_frame_sequencer.sv
// Streams one frame into dft_top, waits for its result frame, captures it and drains it
// on a valid/ready output stream with last.
module dft_frame_sequencer
  import dft_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = DFT_FRAME_WORDS,
  parameter int unsigned DW          = DFT_DW,
  parameter int unsigned TIMEOUT     = DFT_TIMEOUT
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          dft_next_o,
  output logic [DW-1:0] dft_x_o,
  input  logic          dft_next_out_i,
  input  logic [DW-1:0] dft_y_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_o
);

  localparam int unsigned AW = $clog2(FRAME_WORDS);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(FRAME_WORDS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);

  seq_state_e    r_state;
  logic [AW-1:0] r_wcnt;
  logic [AW-1:0] r_fcnt;
  logic [AW-1:0] r_ccnt;
  logic [AW-1:0] r_rcnt;
  logic [TW-1:0] r_tcnt;
  logic          r_next_out_d;
  logic          r_next;
  logic          r_busy;
  logic          r_done;
  logic          r_timeout;
  logic [DW-1:0] r_x;

  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_edge;
  logic          w_cap_we;
  logic [AW-1:0] w_feed_raddr;
  logic [DW-1:0] w_in_rdata;
  logic [DW-1:0] w_out_rdata;

  assign in_ready_o  = !wb_rst_i && (r_state == ST_LOAD);
  assign out_valid_o = !wb_rst_i && (r_state == ST_DRAIN);
  assign out_data_o  = out_valid_o ? w_out_rdata : '0;
  assign out_last_o  = out_valid_o && (r_rcnt == LAST_IDX);

  assign w_in_hs  = in_valid_i && in_ready_o;
  assign w_out_hs = out_valid_o && out_ready_i;
  assign w_edge   = dft_next_out_i && !r_next_out_d;
  assign w_cap_we = (r_state == ST_CAPTURE);

  // The feed register is loaded one word ahead: word 0 in START, word fcnt+1 during FEED.
  assign w_feed_raddr = (r_state == ST_FEED) ? r_fcnt + 1'b1 : '0;

  assign dft_next_o = r_next;
  assign dft_x_o    = r_x;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign timeout_o  = r_timeout;

  dft_seq_buf #(.DEPTH(FRAME_WORDS), .DW(DW)) u_in_buf (
    .i_clk   (wb_clk_i),
    .i_we    (w_in_hs),
    .i_waddr (r_wcnt),
    .i_wdata (in_data_i),
    .i_raddr (w_feed_raddr),
    .o_rdata (w_in_rdata)
  );

  dft_seq_buf #(.DEPTH(FRAME_WORDS), .DW(DW)) u_out_buf (
    .i_clk   (wb_clk_i),
    .i_we    (w_cap_we),
    .i_waddr (r_ccnt),
    .i_wdata (dft_y_i),
    .i_raddr (r_rcnt),
    .o_rdata (w_out_rdata)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_LOAD;
      r_wcnt       <= '0;
      r_fcnt       <= '0;
      r_ccnt       <= '0;
      r_rcnt       <= '0;
      r_tcnt       <= '0;
      r_next_out_d <= 1'b0;
      r_next       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_x          <= '0;
    end else begin
      r_next_out_d <= dft_next_out_i;
      r_next       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_in_hs) begin
            r_busy <= 1'b1;
            if (r_wcnt == LAST_IDX) begin
              r_wcnt  <= '0;
              r_next  <= 1'b1;
              r_state <= ST_START;
            end else begin
              r_wcnt <= r_wcnt + 1'b1;
            end
          end
        end
        ST_START: begin
          r_x     <= w_in_rdata;
          r_fcnt  <= '0;
          r_state <= ST_FEED;
        end
        ST_FEED: begin
          if (w_edge) begin
            r_x     <= '0;
            r_ccnt  <= '0;
            r_state <= ST_CAPTURE;
          end else if (r_fcnt == LAST_IDX) begin
            r_x     <= '0;
            r_tcnt  <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_x    <= w_in_rdata;
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_edge) begin
            r_ccnt  <= '0;
            r_state <= ST_CAPTURE;
          end else if (r_tcnt == LAST_TICK) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_LOAD;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (r_ccnt == LAST_IDX) begin
            r_ccnt  <= '0;
            r_rcnt  <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_ccnt <= r_ccnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_out_hs) begin
            if (r_rcnt == LAST_IDX) begin
              r_rcnt  <= '0;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_LOAD;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Directed bench for dft_frame_sequencer with a small echo model of dft_top (latency 40).
module tb_dft_frame_sequencer;

  localparam int unsigned FW  = 32;
  localparam int unsigned LAT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        out_last;
  logic        dft_next;
  logic [63:0] dft_x;
  logic        nxo = 1'b0;
  logic [63:0] ydat = '0;
  logic        busy;
  logic        done;
  logic        to;

  always #5 clk = ~clk;

  dft_frame_sequencer #(.FRAME_WORDS(FW), .DW(64), .TIMEOUT(1024)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_last_o     (out_last),
    .dft_next_o     (dft_next),
    .dft_x_o        (dft_x),
    .dft_next_out_i (nxo),
    .dft_y_i        (ydat),
    .busy_o         (busy),
    .done_o         (done),
    .timeout_o      (to)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_word(input int unsigned seed, input int unsigned k);
    if (seed == 0) return {4{16'(k)}};
    return {16'(seed + k), 16'(seed * k), 16'(k ^ seed), 16'(16'hC000 + k)};
  endfunction

  // dft_top stand-in: captures the fed frame, raises next_out LAT cycles after next, echoes X as Y.
  logic [63:0] m_mem [FW];
  int unsigned m_cnt = 0;
  int unsigned m_fpos = 0;
  int unsigned m_ycnt = 0;
  bit          m_feeding = 1'b0;
  bit          m_echo = 1'b1;
  bit          spur = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt     <= 0;
      m_fpos    <= 0;
      m_ycnt    <= 0;
      m_feeding <= 1'b0;
      nxo       <= 1'b0;
      ydat      <= '0;
    end else begin
      if (dft_next) begin
        m_cnt     <= 1;
        m_fpos    <= 0;
        m_feeding <= 1'b1;
      end else if (m_cnt != 0 && m_cnt < LAT) begin
        m_cnt <= m_cnt + 1;
      end
      if (m_feeding) begin
        m_mem[m_fpos] <= dft_x;
        m_fpos        <= m_fpos + 1;
        if (m_fpos == FW - 1) m_feeding <= 1'b0;
      end
      nxo <= (m_echo && m_cnt == LAT - 1) || spur;
      if (m_ycnt != 0) begin
        ydat   <= m_mem[m_ycnt - 1];
        m_ycnt <= (m_ycnt == FW) ? 0 : m_ycnt + 1;
      end else if (m_echo && m_cnt == LAT - 1) begin
        m_ycnt <= 1;
      end
    end
  end

  int n_next = 0;
  int n_done = 0;
  int n_to = 0;
  int n_ov = 0;
  int n_rdy_vio = 0;
  bit in_frame = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (done || to) in_frame = 1'b0;
      if (in_frame && in_ready) n_rdy_vio++;
      if (dft_next) begin
        n_next++;
        in_frame = 1'b1;
      end
      if (done) n_done++;
      if (to) n_to++;
      if (out_valid) n_ov++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int unsigned seed, input bit rnd);
    int unsigned k = 0;
    int unsigned guard = 0;
    bit hs;
    while (k < FW && guard < 500) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? mk_word(seed, k) : 64'hBAD0_BAD0_BAD0_BAD0;
      hs = in_valid && in_ready;
      tick();
      if (hs) k++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check_eq("send_count", 64'(k), 64'(FW));
  endtask

  task automatic feed_check(input int unsigned seed);
    check_eq("next_pulse", 64'(dft_next), 64'd1);
    check_eq("x_in_start", dft_x, 64'd0);
    for (int unsigned k = 0; k < FW; k++) begin
      tick();
      check_eq($sformatf("feed%0d", k), dft_x, mk_word(seed, k));
    end
    tick();
    check_eq("x_after_feed", dft_x, 64'd0);
    check_eq("next_single", 64'(dft_next), 64'd0);
  endtask

  task automatic recv_frame(input int unsigned seed, input bit pat, input int spur_k);
    int unsigned k = 0;
    int unsigned guard = 0;
    int unsigned p = 0;
    bit stalled = 1'b0;
    logic [63:0] held = '0;
    logic held_last = 1'b0;
    while (k < FW && guard < 600) begin
      if (stalled) begin
        check_eq("hold_data", out_data, held);
        check_eq("hold_last", 64'(out_last), 64'(held_last));
      end
      out_ready = pat ? (p % 4 == 0 || p % 4 == 3) : 1'b1;
      if (out_valid) p++;
      spur = out_valid && (int'(k) == spur_k);
      if (out_valid && out_ready) begin
        check_eq($sformatf("out%0d", k), out_data, mk_word(seed, k));
        check_eq($sformatf("last%0d", k), 64'(out_last), 64'(k == FW - 1));
        k++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled   = 1'b1;
        held      = out_data;
        held_last = out_last;
      end
      tick();
      guard++;
    end
    spur      = 1'b0;
    out_ready = 1'b0;
    check_eq("recv_count", 64'(k), 64'(FW));
    check_eq("done_pulse", 64'(done), 64'd1);
    tick();
    check_eq("done_single", 64'(done), 64'd0);
    check_eq("ready_after_done", 64'(in_ready), 64'd1);
    check_eq("idle_after_done", 64'(busy), 64'd0);
    check_eq("no_valid_after_done", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d;
    bit found;
    int ov0;

    // reset state
    repeat (3) tick();
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_next", 64'(dft_next), 64'd0);
    check_eq("rst_x", dft_x, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_ready", 64'(in_ready), 64'd1);

    // basic frame + feed timing
    send_frame(0, 1'b0);
    feed_check(0);
    recv_frame(0, 1'b0, -1);
    check_eq("t1_next_count", 64'(n_next), 64'd1);
    check_eq("t1_done_count", 64'(n_done), 64'd1);

    // backpressure with random input gaps
    send_frame(3, 1'b1);
    feed_check(3);
    recv_frame(3, 1'b1, -1);
    check_eq("t3_ready_outside_load", 64'(n_rdy_vio), 64'd0);

    // timeout: core never answers
    m_echo = 1'b0;
    ov0 = n_ov;
    send_frame(5, 1'b0);
    check_eq("t4_next_pulse", 64'(dft_next), 64'd1);
    d = 0;
    found = 1'b0;
    while (d < 1200 && !found) begin
      tick();
      d++;
      if (to) found = 1'b1;
    end
    check_eq("t4_timeout_delay", 64'(d), 64'd1057);
    tick();
    check_eq("t4_timeout_single", 64'(to), 64'd0);
    check_eq("t4_ready_after", 64'(in_ready), 64'd1);
    check_eq("t4_busy_after", 64'(busy), 64'd0);
    check_eq("t4_no_output", 64'(n_ov - ov0), 64'd0);
    m_echo = 1'b1;

    // reset in the middle of capture (ccnt=10)
    send_frame(7, 1'b0);
    feed_check(7);
    repeat (18) tick();
    rst = 1'b1;
    tick();
    check_eq("t5_rst_ready", 64'(in_ready), 64'd0);
    check_eq("t5_rst_valid", 64'(out_valid), 64'd0);
    check_eq("t5_rst_data", out_data, 64'd0);
    check_eq("t5_rst_busy", 64'(busy), 64'd0);
    check_eq("t5_rst_x", dft_x, 64'd0);
    check_eq("t5_rst_flags", {61'd0, dft_next, done, to}, 64'd0);
    rst = 1'b0;
    tick();
    check_eq("t5_ready_after", 64'(in_ready), 64'd1);
    send_frame(9, 1'b0);
    feed_check(9);
    recv_frame(9, 1'b0, -1);

    // spurious next_out during LOAD and DRAIN
    spur = 1'b1;
    tick();
    spur = 1'b0;
    repeat (3) tick();
    check_eq("t6_load_ready", 64'(in_ready), 64'd1);
    check_eq("t6_load_busy", 64'(busy), 64'd0);
    check_eq("t6_load_valid", 64'(out_valid), 64'd0);
    send_frame(11, 1'b0);
    feed_check(11);
    recv_frame(11, 1'b1, 5);

    check_eq("total_next", 64'(n_next), 64'd6);
    check_eq("total_done", 64'(n_done), 64'd4);
    check_eq("total_timeout", 64'(n_to), 64'd1);
    check_eq("total_ready_vio", 64'(n_rdy_vio), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
